// File: rtl/contador.sv
// 4-bit up/down counter with count enable and parallel load from {a,b,c,d}.
// Build option CONTADOR_SAT_EN: saturate at 4'hF / 4'h0 instead of wrapping modulo 16.
module contador #(
    parameter logic [3:0] RESET_VALUE = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       updown,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       load,
    output logic [3:0] cont
);

    localparam int unsigned W = 4;
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_MIN = {W{1'b0}};
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] load_data;
    logic [W-1:0] cont_up;
    logic [W-1:0] cont_dn;
    logic [W-1:0] cont_next;

    assign load_data = {a, b, c, d};

    // Single-step neighbours; the limit behaviour is the only build-dependent part.
`ifdef CONTADOR_SAT_EN
    assign cont_up = (cont == CNT_MAX) ? CNT_MAX : cont + ONE;
    assign cont_dn = (cont == CNT_MIN) ? CNT_MIN : cont - ONE;
`else
    assign cont_up = cont + ONE;
    assign cont_dn = cont - ONE;
`endif

    // Load beats counting; with neither active the value holds.
    always_comb begin
        cont_next = cont;
        if (load) begin
            cont_next = load_data;
        end else if (enable) begin
            cont_next = updown ? cont_up : cont_dn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cont <= RESET_VALUE;
        end else begin
            cont <= cont_next;
        end
    end

endmodule

// File: tb/tb_contador.sv
// Randomized scoreboard bench for contador: stimulus pushes expected values, a monitor pops and compares.
// Honours CONTADOR_SAT_EN in its reference model.
module tb_contador;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       updown;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       load;
    logic [3:0] cont;

    int checks = 0;
    int passes = 0;
    int model  = 0;
    logic [3:0] exp_q[$];

    contador dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .updown (updown),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .load   (load),
        .cont   (cont)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written straight from the counting rules.
    function automatic int model_next(int v, bit en, bit ud, bit ld, int data);
        if (ld) return data;
        if (!en) return v;
`ifdef CONTADOR_SAT_EN
        if (ud) return (v == 15) ? 15 : v + 1;
        return (v == 0) ? 0 : v - 1;
`else
        if (ud) return (v + 1) % 16;
        return (v + 15) % 16;
`endif
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: cont=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    // Drive one edge worth of inputs at the falling edge and queue the result.
    task automatic step(input bit en, input bit ud, input bit ld, input logic [3:0] data);
        @(negedge clk);
        enable = en;
        updown = ud;
        load   = ld;
        {a, b, c, d} = data;
        model = model_next(model, en, ud, ld, int'(data));
        exp_q.push_back(4'(model));
    endtask

    // Short reset pulse between edges; cont must clear without a clock.
    task automatic pulse_reset();
        @(negedge clk);
        enable = 1'b0;
        load   = 1'b0;
        #1 reset = 1'b0;
        #1 check("async_reset", cont, 4'h0);
        model = 0;
        #1 reset = 1'b1;
        exp_q.push_back(4'(model));
    endtask

    // Monitor: every rising edge presents a new cont value.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) check("cont", cont, exp_q.pop_front());
        end
    end

    initial begin
        reset  = 1'b0;
        enable = 1'($urandom);
        updown = 1'($urandom);
        load   = 1'b1;
        {a, b, c, d} = 4'hD;
        #1 check("reset_async_initial", cont, 4'h0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", cont, 4'h0);

        @(negedge clk);
        enable = 1'b0;
        load   = 1'b0;
        reset  = 1'b1;
        model  = 0;
        exp_q.push_back(4'h0);

        // Up count through the wrap (or saturation) point.
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b0, 4'h0);
        // Down count from 2 across zero.
        step(1'b0, 1'b0, 1'b1, 4'h2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'h0);
        // Enable gating at 7 with direction toggling.
        step(1'b0, 1'b0, 1'b1, 4'h7);
        for (int i = 0; i < 5; i++) step(1'b0, 1'(i), 1'b0, 4'(i));
        // Load priority over enable, load held, then resume counting.
        step(1'b1, 1'b0, 1'b1, 4'hA);
        step(1'b1, 1'b0, 1'b1, 4'hB);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        // Reset mid-count at 9, then restart from 0.
        step(1'b0, 1'b1, 1'b1, 4'h8);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        pulse_reset();
        step(1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) pulse_reset();
            else step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(5) == 0), 4'($urandom));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected values left unchecked", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/contador.md
Name: contador

Overview:
- 4-bit synchronous up/down counter with count enable and parallel load from four scalar data inputs.
- General-purpose counting primitive for the lab datapath; drives `cont` directly as a registered output.
- Single clock domain; no handshake.

Parameters:
- RESET_VALUE, 4'h0, value loaded into `cont` while reset is asserted.

Ports:
- clk  input  1  rising-edge clock, sole clock of the block.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  count enable; 1 = count on the next rising edge.
- updown  input  1  direction; 1 = increment, 0 = decrement.
- a  input  1  parallel-load data bit 3 (MSB).
- b  input  1  parallel-load data bit 2.
- c  input  1  parallel-load data bit 1.
- d  input  1  parallel-load data bit 0 (LSB).
- load  input  1  synchronous parallel load; 1 = load {a,b,c,d} on the next rising edge.
- cont  output  4  registered counter value.

Behaviour:
- Reset:
  - reset=0 forces cont=RESET_VALUE immediately, independent of clk.
  - cont holds RESET_VALUE while reset stays 0.
  - The first rising edge with reset=1 evaluates the normal priorities below.
  - Reset asserted mid-count or mid-load aborts the operation; no partial update.
- Priority at each rising clk edge (reset=1):
  1. load=1 -> cont <= {a,b,c,d}. Load ignores enable and updown.
  2. else enable=1, updown=1 -> cont <= cont+1.
  3. else enable=1, updown=0 -> cont <= cont-1.
  4. else -> cont holds.
- Latency: one clock from the input sample to the updated cont. All control and data inputs are sampled only at rising clk edges; glitches between edges have no effect.
- Arithmetic and wrap-around (default build): modulo-16. Up from 4'hF gives 4'h0; down from 4'h0 gives 4'hF.
- Direction change: takes effect on the very next enabled edge; no dead cycle, no extra step.
- Load held high: cont tracks {a,b,c,d} every edge. Counting resumes from the loaded value on the first edge with load=0.
- Load and enable both high: load wins; no count step occurs on that edge.
- Inputs are assumed synchronous to clk; no internal synchronizers.

Optional Feature:
- Macro: CONTADOR_SAT_EN.
- Defined: counter saturates at the limits.
  - Increment at 4'hF holds 4'hF.
  - Decrement at 4'h0 holds 4'h0.
  - Load and reset are unaffected.
- Undefined: modulo-16 wrap-around as in Behaviour.
- Ports and latency are identical in both builds.

Test Plan:
- Reset: reset=0 with any inputs -> cont=4'h0 asynchronously, before any clk edge. Release reset with enable=0 -> cont stays 4'h0.
- Up count with wrap: reset released, enable=1, updown=1 for 18 edges -> cont steps 1,2,…,F,0,1,2. CONTADOR_SAT_EN build: cont stops and holds at F.
- Down count: from cont=4'h2, updown=0, enable=1 for 4 edges -> cont 1,0,F,E. CONTADOR_SAT_EN build: 1,0,0,0.
- Enable gating: enable=0 for 5 edges mid-count at 4'h7 with updown toggling -> cont holds 4'h7.
- Load priority: enable=1, load=1, {a,b,c,d}=1010 -> cont=4'hA on the next edge. Change to 1011 with load still high -> cont=4'hB. Drop load with updown=1 -> next edge cont=4'hC.
- Async reset mid-operation: while counting at 4'h9, pulse reset=0 between clk edges -> cont=4'h0 immediately. After release, counting restarts from 0 on the next enabled edge.
